hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Detects load-use and RAW hazards, generates forwarding selects, flushes on taken branches, and freezes the pipeline while data memory is not ready.
- Instantiated inside CPU alongside the pipeline registers; drives their write-enable and flush controls.

Parameters:
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort.
- CNT_W, 16, stall-cycle counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_AW  ID-stage source A.
- id_rt  in  REG_AW  ID-stage source B.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd  in  REG_AW  EX destination.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  REG_AW  MEM destination.
- mem_reg_write  in  1  MEM instruction writes a register.
- mem_access  in  1  MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- ex_branch_taken  in  1  branch resolved taken in EX.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  zero IF/ID.
- id_ex_bubble  out  1  load NOP into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- fwd_a  out  2  ALU A select: 0 = regfile, 1 = EX/MEM, 2 = MEM/WB.
- fwd_b  out  2  ALU B select, same encoding.
- state  out  2  FSM state.
- timeout_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  saturating stall count.

Behaviour:
- Reset (asynchronous, active-low): state=RUN, timeout counter=0, timeout_err=0, stall_cycles=0.
  - Combinational outputs in reset: pc_write=1, if_id_write=1, all flush/bubble/freeze=0, fwd=0.
- Register 0 never creates a hazard and is never forwarded.
- Control outputs are combinational from current state plus inputs, with zero latency; state and counters update on the Clk rising edge.
- States: RUN=0, MEM_WAIT=1, FLUSH=2, LOAD_STALL=3.
- Priority within a cycle: memory wait > branch flush > load-use.
- Memory wait, from any state, when mem_access=1 and dmem_ready=0:
  - pipe_freeze=1, pc_write=0, if_id_write=0; no flush or bubble.
  - Next state MEM_WAIT; the timeout counter increments each MEM_WAIT cycle.
  - dmem_ready=1 releases: next state RUN, counter cleared.
  - When the counter reaches MEM_TIMEOUT: timeout_err set (sticky until reset), next state RUN; the access is abandoned by the datapath.
- Branch, when ex_branch_taken=1 and no memory wait:
  - if_id_flush=1 and id_ex_bubble=1; pc_write=1 (target loaded).
  - Next state FLUSH.
- FLUSH lasts exactly one cycle. Hazard detection is suppressed in it because ID holds a flushed NOP. Next state RUN.
- Load-use, in RUN when ex_mem_read=1, ex_rd≠0, and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)):
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Next state LOAD_STALL.
- LOAD_STALL lasts one cycle with no stall asserted; the result is forwarded from MEM/WB. Next state RUN.
- A load-use hazard is not re-detected in LOAD_STALL.
- Forwarding, evaluated independently per operand:
  - EX/MEM (value 1) if mem_reg_write, mem_rd≠0, and match.
  - Otherwise MEM/WB (value 2), tracked from the previous-cycle MEM destination registered internally (wb_rd/wb_we).
  - EX/MEM has priority over MEM/WB when both match.
- Internal wb_rd/wb_we are held while pipe_freeze=1.
- stall_cycles increments on every cycle with pc_write=0 and saturates at all-ones.

Optional Feature:
- FORWARDING_EN defined: forwarding as above.
- FORWARDING_EN undefined:
  - fwd_a and fwd_b are tied to 0.
  - Any ID source matching a register-writing EX or MEM destination (≠0) stalls (pc_write=0, if_id_write=0, id_ex_bubble=1) until the producer reaches WB.
  - The register file is write-first, so WB needs no stall.
  - LOAD_STALL is unused.

Decomposition:
- Shared package cpu_pkg:
  - state encodings RUN/MEM_WAIT/FLUSH/LOAD_STALL;
  - forwarding-select constants FWD_RF/FWD_EXMEM/FWD_MEMWB;
  - REG_AW default.
- One natural sub-module: fwd_unit, the per-operand forwarding comparator instantiated twice (A, B).

Test Plan:
- Load-use: `lw $2` in EX, ID `add $3,$2,$4` → one cycle with pc_write=0 and id_ex_bubble=1, then fwd_a=2 next cycle; stall_cycles=1.
- Back-to-back ALU: `add $1` in MEM, ID reads `$1` as rs and rt → fwd_a=1 and fwd_b=1, no stall; with ex_rd=0 and mem_rd=0, fwd=0.
- Branch plus simultaneous load-use: ex_branch_taken=1 and load-use both true → if_id_flush=1, pc_write=1, state→FLUSH, no load stall.
- Memory wait: mem_access=1 with dmem_ready low for 3 cycles → pipe_freeze=1 for 3 cycles, state=MEM_WAIT, stall_cycles=3, RUN after dmem_ready.
- Timeout: dmem_ready held 0 for 20 cycles → timeout_err=1 after 15 MEM_WAIT cycles, state RUN; Reset low mid-MEM_WAIT clears everything immediately.
- FORWARDING_EN undefined: `add $1` in EX with ID reading `$1` → 2 stall cycles, fwd always 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 5-stage CPU pipeline control: FSM states,
// forwarding-select values and the default register address width.
package cpu_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FLUSH      = 2'd2,
        LOAD_STALL = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding comparator: picks EX/MEM over MEM/WB over the
// register file; register 0 is never forwarded.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic              late,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
            // A load sitting in MEM only has its data at MEM/WB.
            sel = late ? FWD_MEMWB : FWD_EXMEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory-wait freeze, branch flush, load-use
// stall and forwarding selects. Define FORWARDING_EN to enable forwarding.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW      = cpu_pkg::REG_AW,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_access,
    input  logic              dmem_ready,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t          cur_state;
    state_t          next_state;
    logic [TW-1:0]   tmo_cnt;
    logic            mem_wait;
    logic            tmo_hit;
    logic            detect_en;
    logic            hazard;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;

    assign mem_wait = mem_access && !dmem_ready;
    assign tmo_hit  = mem_wait && (tmo_cnt == TW'(MEM_TIMEOUT - 1));
    // The MEM_WAIT release cycle advances the pipe, so it must still see hazards.
    assign detect_en = (cur_state == RUN) || (cur_state == MEM_WAIT);
    assign state     = cur_state;

`ifdef FORWARDING_EN
    localparam state_t HAZ_NEXT = LOAD_STALL;

    logic [REG_AW-1:0] wb_rd;
    logic              wb_we;
    logic              late;

    assign late   = (cur_state == LOAD_STALL);
    assign hazard = detect_en && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src(id_rs), .mem_rd(mem_rd), .mem_we(mem_reg_write),
        .wb_rd(wb_rd), .wb_we(wb_we), .late(late), .sel(sel_a)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src(id_rt), .mem_rd(mem_rd), .mem_we(mem_reg_write),
        .wb_rd(wb_rd), .wb_we(wb_we), .late(late), .sel(sel_b)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wb_rd <= '0;
            wb_we <= 1'b0;
        end else if (!pipe_freeze) begin
            wb_rd <= mem_rd;
            wb_we <= mem_reg_write;
        end
    end
`else
    localparam state_t HAZ_NEXT = RUN;

    logic ex_hit;
    logic mem_hit;

    // Without forwarding, any producer still in EX or MEM blocks the reader.
    assign ex_hit  = (ex_reg_write || ex_mem_read) && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_hit = mem_reg_write && (mem_rd != '0) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));
    assign hazard  = detect_en && (ex_hit || mem_hit);
    assign sel_a   = FWD_RF;
    assign sel_b   = FWD_RF;
`endif

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        next_state   = RUN;
        if (Reset) begin
            fwd_a = sel_a;
            fwd_b = sel_b;
            if (mem_wait) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                next_state  = tmo_hit ? RUN : MEM_WAIT;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                next_state   = FLUSH;
            end else if (hazard) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                next_state   = HAZ_NEXT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cur_state    <= RUN;
            tmo_cnt      <= '0;
            timeout_err  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            cur_state <= next_state;
            if (mem_wait && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; follows FORWARDING_EN like the RTL.
module tb_hazard_ctrl;
    import cpu_pkg::*;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
    logic          id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write;
    logic          mem_access, dmem_ready, ex_branch_taken;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
    logic [1:0]    fwd_a, fwd_b, state;
    logic          timeout_err;
    logic [CW-1:0] stall_cycles;
    logic [10:0]   ctl;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
        .dmem_ready(dmem_ready), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    always #5 Clk = ~Clk;

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
                  fwd_a, fwd_b, state};

    function automatic logic [10:0] ctl_v(input logic pc, input logic ifw,
                                          input logic fl, input logic bub,
                                          input logic frz, input logic [1:0] fa,
                                          input logic [1:0] fb, input logic [1:0] st);
        return {pc, ifw, fl, bub, frz, fa, fb, st};
    endfunction

    task automatic idle();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; mem_access = 1'b0;
        dmem_ready = 1'b1; ex_branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        Reset = 1'b0;
        idle();
        mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        mem_rd = 5'd3; mem_reg_write = 1'b1; id_rs = 5'd3;
        tick();
        tick();
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL reset ctl: got %b want %b", ctl, e); end
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", timeout_err); end
        total++;
        if (stall_cycles !== '0) begin bad++; $display("FAIL reset stall: got %0d want 0", stall_cycles); end
        idle();
        Reset = 1'b1;
    endtask

    task automatic test_mem_wait();
        logic [10:0] e;
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            e = ctl_v(0, 0, 0, 0, 1, FWD_RF, FWD_RF, (i == 0) ? RUN : MEM_WAIT);
            total++;
            if (ctl !== e) begin bad++; $display("FAIL mem_wait[%0d] ctl: got %b want %b", i, ctl, e); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, MEM_WAIT);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL mem_release ctl: got %b want %b", ctl, e); end
        tick();
        total++;
        if (state !== RUN) begin bad++; $display("FAIL mem_release state: got %0d want %0d", state, RUN); end
        total++;
        if (stall_cycles !== 4'd3) begin bad++; $display("FAIL mem_wait stall: got %0d want 3", stall_cycles); end
    endtask

    task automatic test_timeout();
        logic [10:0] e;
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            e = ctl_v(0, 0, 0, 0, 1, FWD_RF, FWD_RF, (i == 0) ? RUN : MEM_WAIT);
            total++;
            if (ctl !== e) begin bad++; $display("FAIL timeout[%0d] ctl: got %b want %b", i, ctl, e); end
            tick();
            total++;
            if (timeout_err !== (i == 14)) begin
                bad++; $display("FAIL timeout[%0d] err: got %b want %b", i, timeout_err, (i == 14));
            end
        end
        total++;
        if (state !== RUN) begin bad++; $display("FAIL timeout state: got %0d want %0d", state, RUN); end
        mem_access = 1'b0;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL abandon ctl: got %b want %b", ctl, e); end
        tick();
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL err sticky: got %b want 1", timeout_err); end
        total++;
        if (stall_cycles !== 4'd15) begin bad++; $display("FAIL timeout stall: got %0d want 15", stall_cycles); end
        mem_access = 1'b1;
        tick(); tick(); tick();
        total++;
        if (state !== MEM_WAIT) begin bad++; $display("FAIL rewait state: got %0d want %0d", state, MEM_WAIT); end
        #2;
        Reset = 1'b0;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL midreset ctl: got %b want %b", ctl, e); end
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL midreset err: got %b want 0", timeout_err); end
        total++;
        if (stall_cycles !== '0) begin bad++; $display("FAIL midreset stall: got %0d want 0", stall_cycles); end
        idle();
        tick();
        Reset = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0;
        repeat (18) tick();
        total++;
        if (stall_cycles !== 4'hF) begin bad++; $display("FAIL saturate stall: got %0d want 15", stall_cycles); end
        total++;
        if (state !== MEM_WAIT) begin bad++; $display("FAIL saturate state: got %0d want %0d", state, MEM_WAIT); end
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL saturate err: got %b want 1", timeout_err); end
    endtask

    task automatic test_branch();
        logic [10:0] e;
        do_reset();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        ex_rd = 5'd2; id_rs = 5'd2;
        #1;
        e = ctl_v(1, 1, 1, 1, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL branch ctl: got %b want %b", ctl, e); end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, FLUSH);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL flush ctl: got %b want %b", ctl, e); end
        tick();
        total++;
        if (state !== RUN) begin bad++; $display("FAIL flush exit: got %0d want %0d", state, RUN); end
        total++;
        if (stall_cycles !== '0) begin bad++; $display("FAIL branch stall: got %0d want 0", stall_cycles); end
        idle();
        mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        #1;
        e = ctl_v(0, 0, 0, 0, 1, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL wait_over_branch ctl: got %b want %b", ctl, e); end
        tick();
        dmem_ready = 1'b1;
        #1;
        e = ctl_v(1, 1, 1, 1, 0, FWD_RF, FWD_RF, MEM_WAIT);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL release_branch ctl: got %b want %b", ctl, e); end
        tick();
        total++;
        if (state !== FLUSH) begin bad++; $display("FAIL release_branch state: got %0d want %0d", state, FLUSH); end
    endtask

`ifdef FORWARDING_EN
    task automatic test_load_use();
        logic [10:0] e;
        do_reset();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2;
        id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
        #1;
        e = ctl_v(0, 0, 0, 1, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL load_use ctl: got %b want %b", ctl, e); end
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
        mem_rd = 5'd2; mem_reg_write = 1'b1; mem_access = 1'b1; dmem_ready = 1'b1;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_MEMWB, FWD_RF, LOAD_STALL);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL load_stall ctl: got %b want %b", ctl, e); end
        tick();
        total++;
        if (stall_cycles !== 4'd1) begin bad++; $display("FAIL load_use stall: got %0d want 1", stall_cycles); end
        idle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4;
        id_rs = 5'd3; id_rt = 5'd4; id_uses_rt = 1'b0;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL rt_unused ctl: got %b want %b", ctl, e); end
        ex_rd = '0; id_rs = '0;
        #1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL load_r0 ctl: got %b want %b", ctl, e); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        do_reset();
        mem_rd = 5'd1; mem_reg_write = 1'b1; id_rs = 5'd1; id_rt = 5'd1;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_EXMEM, FWD_EXMEM, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL b2b exmem ctl: got %b want %b", ctl, e); end
        tick();
        mem_rd = 5'd5; id_rt = 5'd5;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_MEMWB, FWD_EXMEM, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL b2b memwb ctl: got %b want %b", ctl, e); end
        tick();
        id_rs = 5'd5;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_EXMEM, FWD_EXMEM, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL b2b priority ctl: got %b want %b", ctl, e); end
        tick();
        mem_rd = '0; ex_rd = '0; ex_reg_write = 1'b1; id_rs = '0; id_rt = '0;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL b2b r0 ctl: got %b want %b", ctl, e); end
        tick();
        ex_reg_write = 1'b0;
        mem_rd = 5'd7; mem_access = 1'b1; dmem_ready = 1'b0; id_rs = 5'd7;
        #1;
        e = ctl_v(0, 0, 0, 0, 1, FWD_EXMEM, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL b2b freeze ctl: got %b want %b", ctl, e); end
        tick();
        mem_access = 1'b0; dmem_ready = 1'b1; mem_rd = 5'd9;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, MEM_WAIT);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL b2b wb_hold ctl: got %b want %b", ctl, e); end
        tick();
    endtask
`else
    task automatic test_no_fwd_stall();
        logic [10:0] e;
        do_reset();
        ex_rd = 5'd1; ex_reg_write = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        #1;
        e = ctl_v(0, 0, 0, 1, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL nofwd ex ctl: got %b want %b", ctl, e); end
        tick();
        ex_rd = '0; ex_reg_write = 1'b0; mem_rd = 5'd1; mem_reg_write = 1'b1;
        #1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL nofwd mem ctl: got %b want %b", ctl, e); end
        tick();
        mem_rd = '0; mem_reg_write = 1'b0;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL nofwd wb ctl: got %b want %b", ctl, e); end
        tick();
        total++;
        if (stall_cycles !== 4'd2) begin bad++; $display("FAIL nofwd stall: got %0d want 2", stall_cycles); end
        ex_rd = 5'd3; ex_reg_write = 1'b1; id_rs = 5'd4; id_rt = 5'd3; id_uses_rt = 1'b0;
        #1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL nofwd rt_unused ctl: got %b want %b", ctl, e); end
        id_uses_rt = 1'b1;
        #1;
        e = ctl_v(0, 0, 0, 1, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL nofwd rt ctl: got %b want %b", ctl, e); end
        idle();
        ex_rd = '0; ex_reg_write = 1'b1; id_rs = '0;
        mem_rd = 5'd6; mem_reg_write = 1'b0; id_rt = 5'd6; id_uses_rt = 1'b1;
        #1;
        e = ctl_v(1, 1, 0, 0, 0, FWD_RF, FWD_RF, RUN);
        total++;
        if (ctl !== e) begin bad++; $display("FAIL nofwd r0/nowrite ctl: got %b want %b", ctl, e); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_branch();
`ifdef FORWARDING_EN
        test_load_use();
        test_back_to_back();
`else
        test_no_fwd_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
